// File: rtl/fp32_pkg.sv
// Shared single-precision constants: operand/result class marks, exponent limits,
// canonical quiet NaN and the divider state encoding.
package fp32_pkg;

    localparam int MARK_NORM = 0;
    localparam int MARK_ZERO = 1;
    localparam int MARK_INF  = 2;
    localparam int MARK_NAN  = 3;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // 24 significand bits + guard + round; the remainder supplies sticky
    localparam int QBITS = 26;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPEC,
        ST_DIV,
        ST_ROUND,
        ST_DONE
    } state_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational one-hot class mark of an IEEE-754 single; denormals are marked zero.
module fp32_classify
    import fp32_pkg::*;
(
    input  logic [31:0] val,
    output logic [4:0]  mark
);

    always_comb begin
        mark = '0;
        if (val[30:23] == 8'h00) begin
            mark[MARK_ZERO] = 1'b1;
        end else if (val[30:23] == 8'hFF) begin
            if (val[22:0] != 23'd0) begin
                mark[MARK_NAN] = 1'b1;
            end else begin
                mark[MARK_INF] = 1'b1;
            end
        end else begin
            mark[MARK_NORM] = 1'b1;
        end
    end

endmodule

// File: rtl/fdiv32_iter.sv
// Iterative single-precision divider: restoring division at one quotient bit per cycle,
// round-to-nearest-even, denormals flushed to zero, result held until out_ready.
module fdiv32_iter
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res,
    output logic [4:0]  res_mark,
    output logic        flag_dz,
    output logic        flag_ovf,
    output logic        flag_unf
);

    localparam logic signed [9:0] EMAX = 10'(EXP_MAX);

    state_t state, state_nxt;

    logic [4:0]  mark1, mark2, rslt_mark;
    logic        sgn;
    logic signed [9:0] expo;
    logic [23:0] divs;
    logic [24:0] rem;
    logic [QBITS-1:0] quo;
    logic [4:0]  cnt;
    logic [31:0] rslt;
    logic        dz_r, ovf_r, unf_r;

    fp32_classify u_cls_op1  (.val(op1),  .mark(mark1));
    fp32_classify u_cls_op2  (.val(op2),  .mark(mark2));
    fp32_classify u_cls_rslt (.val(rslt), .mark(rslt_mark));

    logic        accept, is_spec, s_in;
    logic [23:0] ma_in, mb_in;
    logic [9:0]  exp_in;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid & in_ready;
    assign is_spec  = ~(mark1[MARK_NORM] & mark2[MARK_NORM]);
    assign s_in     = op1[31] ^ op2[31];
    assign ma_in    = {1'b1, op1[22:0]};
    assign mb_in    = {1'b1, op2[22:0]};
    assign exp_in   = {2'b00, op1[30:23]} - {2'b00, op2[30:23]} + 10'(EXP_BIAS);

    logic [31:0] spec_res;
    logic        spec_dz;

    always_comb begin
        spec_res = {s_in, 31'd0};
        spec_dz  = 1'b0;
        if (mark1[MARK_NAN] | mark2[MARK_NAN] | (mark1[MARK_ZERO] & mark2[MARK_ZERO]) |
            (mark1[MARK_INF] & mark2[MARK_INF])) begin
            spec_res = QNAN;
        end else if (mark2[MARK_ZERO]) begin
            spec_res = {s_in, 8'hFF, 23'd0};
            spec_dz  = mark1[MARK_NORM];
        end else if (mark1[MARK_INF]) begin
            spec_res = {s_in, 8'hFF, 23'd0};
        end
    end

    logic        ge;
    logic [24:0] rem_sub;

    assign ge      = (rem >= {1'b0, divs});
    assign rem_sub = ge ? (rem - {1'b0, divs}) : rem;

    // quo[25] is the integer bit, quo[1:0] are guard/round, any remainder left is sticky
    logic        sticky, inc, carry;
    logic [24:0] mant_sum;
    logic [22:0] frac;
    logic signed [9:0] exp_rnd;
    logic [31:0] rnd_res;
    logic        rnd_ovf, rnd_unf;

    always_comb begin
        sticky   = |rem;
        inc      = quo[1] & (quo[0] | sticky | quo[2]);
        mant_sum = {1'b0, quo[QBITS-1:2]} + {24'd0, inc};
        carry    = mant_sum[24];
        frac     = carry ? mant_sum[23:1] : mant_sum[22:0];
        exp_rnd  = expo + {9'd0, carry};
        rnd_ovf  = 1'b0;
        rnd_unf  = 1'b0;
        if (exp_rnd >= EMAX) begin
            rnd_res = {sgn, 8'hFF, 23'd0};
            rnd_ovf = 1'b1;
        end else if (exp_rnd <= 10'sd0) begin
            rnd_res = {sgn, 31'd0};
            rnd_unf = 1'b1;
        end else begin
            rnd_res = {sgn, exp_rnd[7:0], frac};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = is_spec ? ST_SPEC : ST_DIV;
            ST_SPEC:  state_nxt = ST_DONE;
            ST_DIV:   if (cnt == 5'(QBITS - 1)) state_nxt = ST_ROUND;
            ST_ROUND: state_nxt = ST_DONE;
            ST_DONE:  if (out_valid & out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgn       <= 1'b0;
            expo      <= '0;
            divs      <= '0;
            rem       <= '0;
            quo       <= '0;
            cnt       <= '0;
            rslt      <= '0;
            dz_r      <= 1'b0;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
            out_valid <= 1'b0;
            res       <= '0;
            res_mark  <= '0;
            flag_dz   <= 1'b0;
            flag_ovf  <= 1'b0;
            flag_unf  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sgn   <= s_in;
                        divs  <= mb_in;
                        cnt   <= '0;
                        quo   <= '0;
                        rslt  <= spec_res;
                        dz_r  <= spec_dz;
                        ovf_r <= 1'b0;
                        unf_r <= 1'b0;
                        // pre-normalise so the first quotient bit is always the integer 1
                        if (ma_in < mb_in) begin
                            rem  <= {ma_in, 1'b0};
                            expo <= exp_in - 10'd1;
                        end else begin
                            rem  <= {1'b0, ma_in};
                            expo <= exp_in;
                        end
                    end
                end
                ST_DIV: begin
                    rem <= {rem_sub[23:0], 1'b0};
                    quo <= {quo[QBITS-2:0], ge};
                    cnt <= cnt + 5'd1;
                end
                ST_ROUND: begin
                    rslt  <= rnd_res;
                    ovf_r <= rnd_ovf;
                    unf_r <= rnd_unf;
                end
                ST_DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        res       <= rslt;
                        res_mark  <= rslt_mark;
                        flag_dz   <= dz_r;
                        flag_ovf  <= ovf_r;
                        flag_unf  <= unf_r;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        flag_dz   <= 1'b0;
                        flag_ovf  <= 1'b0;
                        flag_unf  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
